ahb_mux_s2m: RTL
================

# ahb_mux_s2m

Slave-to-master return path of the AHB interconnect: decodes the shared address bus into slave selects, remembers which slave owns the current data phase, and multiplexes that slave's HRDATA/HREADY/HRESP back to the bus. Embeds a default slave that answers unmapped accesses with the two-cycle ERROR response. Sits between the master-to-slave multiplexer's outputs and the two attached slaves.

## Interface
- AHB_ADDR_BITS, 32, address width (shared macro)
- AHB_DATA_BITS, 32, data width (shared macro)
- S1_BASE, 32'h0000_0000, slave 1 base address
- S1_MASK, 32'hFFFF_0000, slave 1 compare mask (hit when (HADDR & S1_MASK) == S1_BASE)
- S2_BASE, 32'h0001_0000, slave 2 base address
- S2_MASK, 32'hFFFF_0000, slave 2 compare mask
- HCLK  in  1  bus clock; one clock, rising edge
- HRESET  in  1  reset, asynchronous, active-high
- HADDR  in  AHB_ADDR_BITS  muxed address-phase address
- HTRANS  in  2  muxed transfer type (IDLE 0, BUSY 1, NONSEQ 2, SEQ 3)
- HSEL_S1 / HSEL_S2  out  1  combinational address decode selects
- HRDATA_S1 / HRDATA_S2  in  AHB_DATA_BITS  slave read data
- HREADY_S1 / HREADY_S2  in  1  slave ready outputs
- HRESP_S1 / HRESP_S2  in  2  slave responses (OKAY 0, ERROR 1, RETRY 2, SPLIT 3)
- HRDATA  out  AHB_DATA_BITS  read data to masters
- HREADY  out  1  bus ready, also fed to all slaves and the arbiter
- HRESP  out  2  response to masters

## Operation
- Address decode (combinational, ignores HTRANS): S1 hit → HSEL_S1=1; else S2 hit → HSEL_S2=1; else default selected. Overlapping regions: S1 wins. At most one HSEL high.
- Data-phase select register DSEL ∈ {S1, S2, DEF}: loads the decode result on a rising edge when HREADY=1; holds when HREADY=0.
- Return mux driven by DSEL: S1/S2 → that slave's HRDATA/HREADY/HRESP passed through; DEF → default slave outputs, HRDATA=0.
- Default slave FSM (states DS_IDLE, DS_ERR1, DS_ERR2):
  - DS_IDLE: HREADY=1, HRESP=OKAY. Go DS_ERR1 when HREADY=1, decode=DEF and HTRANS is NONSEQ or SEQ.
  - DS_ERR1: HREADY=0, HRESP=ERROR. Always go DS_ERR2.
  - DS_ERR2: HREADY=1, HRESP=ERROR. Go DS_ERR1 if a new NONSEQ/SEQ default access is accepted this cycle, else DS_IDLE.
  - IDLE/BUSY to unmapped space: zero-wait OKAY, FSM stays in DS_IDLE.
- FSM outputs only reach the bus when DSEL=DEF.

## Timing
- Reset (HRESET=1, asynchronous): DSEL=DEF, FSM=DS_IDLE → HREADY=1, HRESP=OKAY, HRDATA=0 immediately and until the first accepted transfer. Reset asserted mid-transfer aborts it; outputs return to these values without waiting for a clock.
- Decode-to-HSEL: zero cycles (combinational). HSEL→DSEL: one cycle, gated by HREADY.
- Slave return path: zero added latency; slave wait states propagate unchanged.
- Unmapped NONSEQ/SEQ: data phase lasts exactly two cycles (ERR1 then ERR2); back-to-back unmapped transfers give ERR1,ERR2,ERR1,ERR2.
- Switching slaves: the new slave's outputs appear on the cycle after the last HREADY=1 of the previous data phase; no gap cycle.

## Structure
- Shared package ahb_pkg: htrans_t (IDLE/BUSY/NONSEQ/SEQ), hresp_t (OKAY/ERROR/RETRY/SPLIT), dsel_t (S1/S2/DEF); reused by the master-side mux and arbiter.
- One sub-module: ahb_default_slave (FSM plus its HREADY/HRESP), instantiated once; decode, DSEL register and return mux stay in the top.

## Test plan
- Reset: hold HRESET 3 cycles, release → HREADY=1, HRESP=0, HRDATA=0, HSEL_S1=HSEL_S2=0 for HADDR=32'hFFFF_0000.
- Read S1: NONSEQ HADDR=32'h0000_0010, slave 1 returns 32'hDEAD_BEEF with 2 wait states → HSEL_S1=1 in address phase, HREADY low 2 cycles, then HRDATA=32'hDEAD_BEEF, HRESP=OKAY.
- Pipelined S1→S2: NONSEQ 32'h0000_0004 then 32'h0001_0008 on consecutive cycles, S1 stalls 1 cycle → S2's HRDATA reaches the bus only after S1's final HREADY=1, no dropped or duplicated phase.
- Unmapped NONSEQ 32'h8000_0000 → next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, then DS_IDLE OKAY.
- IDLE to 32'h8000_0000 → zero-wait HREADY=1, HRESP=0; back-to-back unmapped SEQ pair → ERR1,ERR2,ERR1,ERR2.
- Overlap (S2_BASE=S1_BASE) → only HSEL_S1 asserted; HRESET pulsed during ERR1 → HREADY=1, HRESP=OKAY asynchronously.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB types for the interconnect: transfer type, response code and
// data-phase owner encoding used by both the muxes and the arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [1:0] {
    HR_OKAY  = 2'd0,
    HR_ERROR = 2'd1,
    HR_RETRY = 2'd2,
    HR_SPLIT = 2'd3
  } hresp_t;

  typedef enum logic [1:0] {
    DSEL_S1  = 2'd0,
    DSEL_S2  = 2'd1,
    DSEL_DEF = 2'd2
  } dsel_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  // NONSEQ and SEQ carry data; IDLE and BUSY never do.
  function automatic logic is_active(input htrans_t t);
    return (t == HT_NONSEQ) || (t == HT_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped space: answers an accepted NONSEQ/SEQ with the
// two-cycle ERROR response, everything else with a zero-wait OKAY.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic    HCLK,
  input  logic    HRESET,
  input  logic    hready,
  input  logic    def_sel,
  input  htrans_t htrans,
  output logic    ds_hready,
  output hresp_t  ds_hresp
);

  ds_state_t st, st_nxt;
  logic      accept;

  // A new default-slave data phase starts only when the bus is ready.
  assign accept = hready & def_sel & is_active(htrans);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) st <= DS_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      DS_IDLE: if (accept) st_nxt = DS_ERR1;
      DS_ERR1: st_nxt = DS_ERR2;
      DS_ERR2: st_nxt = accept ? DS_ERR1 : DS_IDLE;
      default: st_nxt = DS_IDLE;
    endcase
  end

  always_comb begin
    ds_hready = 1'b1;
    ds_hresp  = HR_OKAY;
    case (st)
      DS_ERR1: begin ds_hready = 1'b0; ds_hresp = HR_ERROR; end
      DS_ERR2: begin ds_hready = 1'b1; ds_hresp = HR_ERROR; end
      default: begin ds_hready = 1'b1; ds_hresp = HR_OKAY;  end
    endcase
  end

endmodule

// File: rtl/ahb_mux_s2m.sv
// Slave-to-master return path: address decode, data-phase owner register and
// the HRDATA/HREADY/HRESP return mux, with an embedded default slave.
module ahb_mux_s2m
  import ahb_pkg::*;
#(
  parameter int           AHB_ADDR_BITS = 32,
  parameter int           AHB_DATA_BITS = 32,
  parameter logic [31:0]  S1_BASE       = 32'h0000_0000,
  parameter logic [31:0]  S1_MASK       = 32'hFFFF_0000,
  parameter logic [31:0]  S2_BASE       = 32'h0001_0000,
  parameter logic [31:0]  S2_MASK       = 32'hFFFF_0000
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [AHB_ADDR_BITS-1:0] HADDR,
  input  logic [1:0]               HTRANS,
  output logic                     HSEL_S1,
  output logic                     HSEL_S2,
  input  logic [AHB_DATA_BITS-1:0] HRDATA_S1,
  input  logic [AHB_DATA_BITS-1:0] HRDATA_S2,
  input  logic                     HREADY_S1,
  input  logic                     HREADY_S2,
  input  logic [1:0]               HRESP_S1,
  input  logic [1:0]               HRESP_S2,
  output logic [AHB_DATA_BITS-1:0] HRDATA,
  output logic                     HREADY,
  output logic [1:0]               HRESP
);

  localparam logic [AHB_ADDR_BITS-1:0] B1 = AHB_ADDR_BITS'(S1_BASE);
  localparam logic [AHB_ADDR_BITS-1:0] M1 = AHB_ADDR_BITS'(S1_MASK);
  localparam logic [AHB_ADDR_BITS-1:0] B2 = AHB_ADDR_BITS'(S2_BASE);
  localparam logic [AHB_ADDR_BITS-1:0] M2 = AHB_ADDR_BITS'(S2_MASK);

  dsel_t  dec, dsel;
  logic   bus_ready;
  logic   ds_hready;
  hresp_t ds_hresp;

  // S1 is tested first so it wins when regions overlap.
  always_comb begin
    dec = DSEL_DEF;
    if      ((HADDR & M1) == B1) dec = DSEL_S1;
    else if ((HADDR & M2) == B2) dec = DSEL_S2;
  end

  assign HSEL_S1 = (dec == DSEL_S1);
  assign HSEL_S2 = (dec == DSEL_S2);

  // Owner of the data phase; advances only when the previous phase completes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)         dsel <= DSEL_DEF;
    else if (bus_ready) dsel <= dec;
  end

  ahb_default_slave u_def (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .hready    (bus_ready),
    .def_sel   (dec == DSEL_DEF),
    .htrans    (htrans_t'(HTRANS)),
    .ds_hready (ds_hready),
    .ds_hresp  (ds_hresp)
  );

  always_comb begin
    HRDATA    = '0;
    bus_ready = ds_hready;
    HRESP     = ds_hresp;
    case (dsel)
      DSEL_S1: begin HRDATA = HRDATA_S1; bus_ready = HREADY_S1; HRESP = HRESP_S1; end
      DSEL_S2: begin HRDATA = HRDATA_S2; bus_ready = HREADY_S2; HRESP = HRESP_S2; end
      default: begin HRDATA = '0;        bus_ready = ds_hready; HRESP = ds_hresp; end
    endcase
  end

  assign HREADY = bus_ready;

endmodule
